// File: rtl/sitcp_tx_pkg.sv
// Shared types and helpers for the SiTCP TX aggregator: framer states and header layout.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package sitcp_tx_pkg;

    // Framer states: one arbitration cycle, four header bytes, then payload
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_H0,
        ST_H1,
        ST_H2,
        ST_H3,
        ST_DATA
    } tx_state_t;

    // Position of each byte inside the 4-byte frame header
    localparam logic [1:0] HDR_SYNC   = 2'd0;
    localparam logic [1:0] HDR_CHAN   = 2'd1;
    localparam logic [1:0] HDR_LEN_HI = 2'd2;
    localparam logic [1:0] HDR_LEN_LO = 2'd3;

    // Header byte index emitted from a given header state
    function automatic logic [1:0] hdr_index(input tx_state_t st);
        case (st)
            ST_H1:   hdr_index = HDR_CHAN;
            ST_H2:   hdr_index = HDR_LEN_HI;
            ST_H3:   hdr_index = HDR_LEN_LO;
            default: hdr_index = HDR_SYNC;
        endcase
    endfunction

    // State that follows a header state once its byte has been accepted
    function automatic tx_state_t hdr_next(input tx_state_t st);
        case (st)
            ST_H0:   hdr_next = ST_H1;
            ST_H1:   hdr_next = ST_H2;
            ST_H2:   hdr_next = ST_H3;
            default: hdr_next = ST_DATA;
        endcase
    endfunction

    // Header byte value for a given index
    function automatic logic [7:0] hdr_byte(input logic [1:0]  idx,
                                            input logic [7:0]  sync,
                                            input logic [3:0]  ch,
                                            input logic [15:0] len);
        case (idx)
            HDR_CHAN:   hdr_byte = {4'h0, ch};
            HDR_LEN_HI: hdr_byte = len[15:8];
            HDR_LEN_LO: hdr_byte = len[7:0];
            default:    hdr_byte = sync;
        endcase
    endfunction

endpackage

// File: rtl/sitcp_tx_mux_if.sv
// Channel write side and SiTCP byte-stream side of the TX aggregator.
// Latency: n/a (wiring only).
// Backpressure: TCP_TX_FULL from SiTCP; CH_FULL_OUT/CH_OVF_OUT toward the sources.
interface sitcp_tx_mux_if #(
    parameter int N_CH = 4
);
    logic [N_CH*8-1:0] CH_DATA_IN;
    logic [N_CH-1:0]   CH_EN_IN;
    logic [N_CH-1:0]   CH_FULL_OUT;
    logic [N_CH-1:0]   CH_OVF_OUT;
    logic              TCP_TX_FULL;
    logic              TCP_TX_WR;
    logic [7:0]        TCP_TX_DATA;

    // The aggregator itself
    modport master (
        input  CH_DATA_IN, CH_EN_IN, TCP_TX_FULL,
        output CH_FULL_OUT, CH_OVF_OUT, TCP_TX_WR, TCP_TX_DATA
    );

    // Data sources plus SiTCP
    modport slave (
        output CH_DATA_IN, CH_EN_IN, TCP_TX_FULL,
        input  CH_FULL_OUT, CH_OVF_OUT, TCP_TX_WR, TCP_TX_DATA
    );
endinterface

// File: rtl/sitcp_tx_fifo.sv
// Per-channel byte FIFO, first-word-fall-through, with synchronous clear and prog-full flag.
// Latency: a written byte is visible on dout the cycle after the write edge.
// Backpressure: writes while full are discarded; reads while empty are ignored.
module sitcp_tx_fifo #(
    parameter int AW       = 11,
    parameter int PFULL_TH = 1920
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          clr,
    input  logic [7:0]    din,
    input  logic          wr,
    input  logic          rd,
    output logic [7:0]    dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          prog_full
);
    localparam int DEPTH = 1 << AW;
    localparam int CW    = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign do_wr     = wr & ~full;
    assign do_rd     = rd & (count != '0);
    assign full      = (count == CW'(DEPTH));
    assign prog_full = (count >= CW'(PFULL_TH));
    assign dout      = mem[rd_ptr];

    // Storage array, no reset needed: only entries below count are ever read
    always_ff @(posedge CLK) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; simultaneous read and write leave count unchanged
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sitcp_tx_mux.sv
// N-channel round-robin TX aggregator: frames bursts as A5,ch,LENh,LENl,payload into SiTCP.
// Latency: first header byte two cycles after a byte lands in an idle FIFO; LEN+5 cycles per frame.
// Backpressure: TCP_TX_FULL high holds the framer in place; byte strobe drops the next cycle.
module sitcp_tx_mux
    import sitcp_tx_pkg::*;
#(
    parameter int         N_CH      = 4,
    parameter int         FIFO_AW   = 11,
    parameter int         PFULL_TH  = 1920,
    parameter int         MAX_BURST = 256,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           TCP_OPEN_ACK,
    input  logic           SOFT_RESET,
    sitcp_tx_mux_if.master bus
);
    localparam int          CHW     = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int          CW      = FIFO_AW + 1;
    localparam logic [15:0] MAX_LEN = 16'(MAX_BURST);

    logic            flush;
    logic [N_CH-1:0] fifo_wr;
    logic [N_CH-1:0] fifo_rd;
    logic [N_CH-1:0] fifo_full;
    logic [N_CH-1:0] fifo_pfull;
    logic [N_CH-1:0] fifo_nempty;
    logic [7:0]      fifo_dout [N_CH];
    logic [CW-1:0]   fifo_cnt  [N_CH];
    logic [N_CH-1:0] ovf;

    tx_state_t       state;
    logic [CHW-1:0]  cur_ch;     // also the round-robin pointer: last granted channel
    logic [15:0]     len;        // frame length in headers, remaining bytes during payload
    logic            tx_wr;
    logic [7:0]      tx_data;
    logic [3:0]      cur_nib;

    logic            gnt_vld;
    logic [CHW-1:0]  gnt_ch;
    logic [15:0]     gnt_len;

    assign flush   = ~TCP_OPEN_ACK | SOFT_RESET;
    assign cur_nib = 4'(cur_ch);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign fifo_wr[c]     = bus.CH_EN_IN[c] & ~flush;
        assign fifo_rd[c]     = (state == ST_DATA) && !bus.TCP_TX_FULL && !flush
                                && (cur_ch == CHW'(c));
        assign fifo_nempty[c] = (fifo_cnt[c] != '0);

        sitcp_tx_fifo #(
            .AW       (FIFO_AW),
            .PFULL_TH (PFULL_TH)
        ) u_fifo (
            .CLK       (CLK),
            .RST       (RST),
            .clr       (flush),
            .din       (bus.CH_DATA_IN[8*c +: 8]),
            .wr        (fifo_wr[c]),
            .rd        (fifo_rd[c]),
            .dout      (fifo_dout[c]),
            .count     (fifo_cnt[c]),
            .full      (fifo_full[c]),
            .prog_full (fifo_pfull[c])
        );
    end

    // Round-robin pick: first non-empty channel after the last grant, wrapping
    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx = int'(cur_ch) + 1 + i;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (!gnt_vld && fifo_nempty[CHW'(idx)]) begin
                gnt_vld = 1'b1;
                gnt_ch  = CHW'(idx);
            end
        end
    end

    // Burst length for the winner, compared at full width so large FIFOs clip correctly
    always_comb begin
        gnt_len = MAX_LEN;
        if (32'(fifo_cnt[gnt_ch]) <= MAX_BURST) begin
            gnt_len = 16'(fifo_cnt[gnt_ch]);
        end
    end

    // Framer: grant in IDLE, then one header or payload byte per unblocked cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_IDLE;
            cur_ch  <= '0;
            len     <= '0;
            tx_wr   <= 1'b0;
            tx_data <= '0;
        end else if (flush) begin
            state   <= ST_IDLE;
            tx_wr   <= 1'b0;
        end else begin
            tx_wr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        cur_ch <= gnt_ch;
                        len    <= gnt_len;
                        state  <= ST_H0;
                    end
                end
                ST_H0, ST_H1, ST_H2, ST_H3: begin
                    if (!bus.TCP_TX_FULL) begin
                        tx_wr   <= 1'b1;
                        tx_data <= hdr_byte(hdr_index(state), SYNC_BYTE, cur_nib, len);
                        state   <= hdr_next(state);
                    end
                end
                ST_DATA: begin
                    if (!bus.TCP_TX_FULL) begin
                        tx_wr   <= 1'b1;
                        tx_data <= fifo_dout[cur_ch];
                        len     <= len - 16'd1;
                        if (len == 16'd1) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky overflow: a write strobe that met a completely full FIFO
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf <= '0;
        end else if (flush) begin
            ovf <= '0;
        end else begin
            ovf <= ovf | (bus.CH_EN_IN & fifo_full);
        end
    end

    assign bus.CH_FULL_OUT = fifo_pfull;
    assign bus.CH_OVF_OUT  = ovf;
    assign bus.TCP_TX_WR   = tx_wr;
    assign bus.TCP_TX_DATA = tx_data;

endmodule

// File: tb/tb_sitcp_tx_mux.sv
// Bench for sitcp_tx_mux: directed frames, expected bytes queued by stimulus, popped by a monitor.
module tb_sitcp_tx_mux;
    logic CLK = 1'b0;
    logic RST;
    logic TCP_OPEN_ACK;
    logic SOFT_RESET;

    sitcp_tx_mux_if #(.N_CH(4)) bus();

    sitcp_tx_mux #(
        .N_CH      (4),
        .FIFO_AW   (11),
        .PFULL_TH  (1920),
        .MAX_BURST (256),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .TCP_OPEN_ACK (TCP_OPEN_ACK),
        .SOFT_RESET   (SOFT_RESET),
        .bus          (bus)
    );

    always #5 CLK = ~CLK;

    logic [7:0] exp_q[$];
    int         runs[$];
    int         run_len  = 0;
    int         seen     = 0;
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every strobed byte must match the head of the expected queue
    always @(negedge CLK) begin
        if (bus.TCP_TX_WR) begin
            run_len++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_byte: got 0x%0h with nothing expected", bus.TCP_TX_DATA);
            end else begin
                check($sformatf("byte%0d", seen), int'(bus.TCP_TX_DATA), int'(exp_q.pop_front()));
            end
            seen++;
        end else if (run_len != 0) begin
            runs.push_back(run_len);
            run_len = 0;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, %0d bytes seen", seen);
        $fatal(1);
    end

    task automatic wr_byte(input int ch, input logic [7:0] val);
        bus.CH_DATA_IN[8*ch +: 8] = val;
        bus.CH_EN_IN[ch] = 1'b1;
        @(posedge CLK); #1;
        bus.CH_EN_IN[ch] = 1'b0;
    endtask

    task automatic push_hdr(input int ch, input int len);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(ch));
        exp_q.push_back(8'(len >> 8));
        exp_q.push_back(8'(len));
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge CLK); k++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic wait_seen(input int target, input int budget);
        int k = 0;
        while (seen < target && k < budget) begin
            @(posedge CLK); #1; k++;
        end
        check("wait_seen", int'(seen >= target), 1);
    endtask

    initial begin
        int s0;
        RST             = 1'b1;
        TCP_OPEN_ACK    = 1'b1;
        SOFT_RESET      = 1'b0;
        bus.CH_DATA_IN  = '0;
        bus.CH_EN_IN    = '0;
        bus.TCP_TX_FULL = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(posedge CLK); #1;

        check("rst_wr",   bus.TCP_TX_WR,   0);
        check("rst_data", bus.TCP_TX_DATA, 0);
        check("rst_full", bus.CH_FULL_OUT, 0);
        check("rst_ovf",  bus.CH_OVF_OUT,  0);

        // 1: ch3 primer holds the framer; ch0 then goes out as one 7-byte run
        wr_byte(3, 8'h77);
        push_hdr(3, 1); exp_q.push_back(8'h77);
        wr_byte(0, 8'h01); wr_byte(0, 8'h02); wr_byte(0, 8'h03);
        push_hdr(0, 3);
        exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
        runs.delete();
        bus.TCP_TX_FULL = 1'b0;
        wait_drain("t1", 100);
        check("t1_run_count", runs.size(), 2);
        if (runs.size() == 2) begin
            check("t1_run_primer", runs[0], 5);
            check("t1_run_ch0",    runs[1], 7);
        end

        // 2a: last grant ch0; ch1 and ch3 loaded -> ch1 then ch3
        bus.TCP_TX_FULL = 1'b1;
        wr_byte(0, 8'h0A);
        push_hdr(0, 1); exp_q.push_back(8'h0A);
        wr_byte(1, 8'h11); wr_byte(1, 8'h12); wr_byte(3, 8'h31); wr_byte(3, 8'h32);
        push_hdr(1, 2); exp_q.push_back(8'h11); exp_q.push_back(8'h12);
        push_hdr(3, 2); exp_q.push_back(8'h31); exp_q.push_back(8'h32);
        bus.TCP_TX_FULL = 1'b0;
        wait_drain("t2a", 100);

        // 2b: primer on ch1, ch1 and ch2 refilled -> ch2 first, ch1 after wrap
        bus.TCP_TX_FULL = 1'b1;
        wr_byte(1, 8'h1A);
        push_hdr(1, 1); exp_q.push_back(8'h1A);
        wr_byte(1, 8'h13); wr_byte(1, 8'h14); wr_byte(2, 8'h21); wr_byte(2, 8'h22);
        push_hdr(2, 2); exp_q.push_back(8'h21); exp_q.push_back(8'h22);
        push_hdr(1, 2); exp_q.push_back(8'h13); exp_q.push_back(8'h14);
        bus.TCP_TX_FULL = 1'b0;
        wait_drain("t2b", 100);

        // 3: 600 bytes on ch0 split 256/256/88, ch3 and ch1 interleaved
        bus.TCP_TX_FULL = 1'b1;
        wr_byte(2, 8'h2A);
        push_hdr(2, 1); exp_q.push_back(8'h2A);
        for (int i = 0; i < 600; i++) wr_byte(0, 8'(i ^ (i >> 8)));
        wr_byte(3, 8'h33); wr_byte(3, 8'h34); wr_byte(1, 8'h15);
        push_hdr(3, 2); exp_q.push_back(8'h33); exp_q.push_back(8'h34);
        push_hdr(0, 256);
        for (int i = 0; i < 256; i++) exp_q.push_back(8'(i ^ (i >> 8)));
        push_hdr(1, 1); exp_q.push_back(8'h15);
        push_hdr(0, 256);
        for (int i = 256; i < 512; i++) exp_q.push_back(8'(i ^ (i >> 8)));
        push_hdr(0, 88);
        for (int i = 512; i < 600; i++) exp_q.push_back(8'(i ^ (i >> 8)));
        bus.TCP_TX_FULL = 1'b0;
        wait_drain("t3", 2000);

        // 4: stall 5 cycles in the middle of ch2's payload
        bus.TCP_TX_FULL = 1'b1;
        wr_byte(1, 8'h1B);
        push_hdr(1, 1); exp_q.push_back(8'h1B);
        for (int i = 0; i < 8; i++) wr_byte(2, 8'(8'h40 + i));
        push_hdr(2, 8);
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'h40 + i));
        s0 = seen;
        bus.TCP_TX_FULL = 1'b0;
        wait_seen(s0 + 12, 100);
        bus.TCP_TX_FULL = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); @(negedge CLK);
            check($sformatf("t4_hold_wr%0d", i), bus.TCP_TX_WR, 0);
        end
        bus.TCP_TX_FULL = 1'b0;
        @(posedge CLK); #1;
        wait_drain("t4", 100);

        // 5: 2049 writes to ch2 while blocked: prog-full at 1920, overflow on the last
        bus.TCP_TX_FULL = 1'b1;
        for (int i = 0; i < 2049; i++) begin
            wr_byte(2, 8'(i));
            if (i == 1918) check("t5_pfull_1919", bus.CH_FULL_OUT[2], 0);
            if (i == 1919) check("t5_pfull_1920", bus.CH_FULL_OUT[2], 1);
            if (i == 2047) check("t5_ovf_2048",   bus.CH_OVF_OUT[2],  0);
            if (i == 2048) check("t5_ovf_2049",   bus.CH_OVF_OUT[2],  1);
        end
        push_hdr(2, 1); exp_q.push_back(8'h00);
        for (int f = 0; f < 7; f++) begin
            push_hdr(2, 256);
            for (int j = 0; j < 256; j++) exp_q.push_back(8'(1 + f*256 + j));
        end
        push_hdr(2, 255);
        for (int j = 1793; j < 2048; j++) exp_q.push_back(8'(j));
        bus.TCP_TX_FULL = 1'b0;
        wait_drain("t5", 4000);
        check("t5_pfull_after", bus.CH_FULL_OUT[2], 0);
        check("t5_ovf_sticky",  bus.CH_OVF_OUT[2],  1);

        // 6: connection drops mid-payload; abandoned frame, clean restart
        bus.TCP_TX_FULL = 1'b1;
        wr_byte(3, 8'h3C);
        push_hdr(3, 1); exp_q.push_back(8'h3C);
        for (int i = 0; i < 20; i++) wr_byte(0, 8'(8'h80 + i));
        push_hdr(0, 20);
        for (int i = 0; i < 20; i++) exp_q.push_back(8'(8'h80 + i));
        s0 = seen;
        bus.TCP_TX_FULL = 1'b0;
        wait_seen(s0 + 14, 100);
        TCP_OPEN_ACK = 1'b0;
        @(posedge CLK); #1;
        exp_q.delete();
        @(negedge CLK);
        check("t6_wr_after_drop", bus.TCP_TX_WR,   0);
        check("t6_ovf_cleared",   bus.CH_OVF_OUT,  0);
        check("t6_pfull_cleared", bus.CH_FULL_OUT, 0);
        @(posedge CLK); #1;
        wr_byte(1, 8'hEE);
        TCP_OPEN_ACK = 1'b1;
        s0 = seen;
        repeat (20) @(posedge CLK);
        #1;
        check("t6_silent_after_reopen", seen - s0, 0);
        wr_byte(1, 8'h41);
        push_hdr(1, 1); exp_q.push_back(8'h41);
        wait_drain("t6", 100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
